// File: rtl/arb_rr_lock.sv
// Round-robin arbiter with burst locking: a granted requester keeps the shared
// port until its last beat, an abort (request dropped), or the beat limit.
module arb_rr_lock #(
  parameter int N         = 8,
  parameter int MAX_BEATS = 16,
  parameter int IDW       = $clog2(N)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req_i,
  input  logic [N-1:0]   last_i,
  output logic [N-1:0]   ack_i,
  output logic           req_o,
  input  logic           ack_o,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           busy_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_e;

  localparam logic [15:0]    BEAT_LIMIT = 16'(MAX_BEATS - 1);
  localparam logic [IDW:0]   N_EXT      = (IDW+1)'(N);
  localparam logic [IDW-1:0] LAST_IDX   = IDW'(N - 1);
  localparam logic [N-1:0]   ONE_HOT0   = {{(N-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gntId_q, gntId_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    beatCnt_q, beatCnt_d;

  logic           winValid;
  logic [IDW-1:0] winIdx;
  logic [IDW:0]   scanSum;
  logic [IDW-1:0] scanIdx;

  logic           inLock;
  logic           ownerReq;
  logic           beat;
  logic           releaseNow;
  logic [IDW-1:0] nextPtr;

  // Rotating-priority scan: walking offsets downward lets the smallest offset
  // from ptr (the highest priority) overwrite any earlier candidate.
  always_comb begin
    winValid = 1'b0;
    winIdx   = '0;
    scanSum  = '0;
    scanIdx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scanSum = {1'b0, ptr_q} + (IDW+1)'(i);
      if (scanSum >= N_EXT) begin
        scanSum = scanSum - N_EXT;
      end
      scanIdx = scanSum[IDW-1:0];
      if (req_i[scanIdx]) begin
        winValid = 1'b1;
        winIdx   = scanIdx;
      end
    end
  end

  assign inLock     = (state_q == S_LOCK);
  assign ownerReq   = req_i[gntId_q];
  assign req_o      = inLock & ownerReq;
  assign beat       = req_o & ack_o;
  assign ack_i      = gnt_q & {N{beat}};
  assign releaseNow = inLock & (~ownerReq | (beat & (last_i[gntId_q] | (beatCnt_q == BEAT_LIMIT))));
  assign nextPtr    = (gntId_q == LAST_IDX) ? '0 : gntId_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gntId_d   = gntId_q;
    ptr_d     = ptr_q;
    beatCnt_d = beatCnt_q;
    case (state_q)
      S_IDLE: begin
        if (winValid) begin
          state_d   = S_LOCK;
          gnt_d     = ONE_HOT0 << winIdx;
          gntId_d   = winIdx;
          beatCnt_d = '0;
        end
      end
      S_LOCK: begin
        if (beat) begin
          beatCnt_d = beatCnt_q + 16'd1;
        end
        // The owner index is kept on release so gnt_id_o reports the last owner.
        if (releaseNow) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          ptr_d   = nextPtr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      gntId_q   <= '0;
      ptr_q     <= '0;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gntId_q   <= gntId_d;
      ptr_q     <= ptr_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign gnt_id_o = gntId_q;
  assign busy_o   = inLock;

endmodule

// File: doc/arb_rr_lock.md
Name: arb_rr_lock

Overview:
- N-way round-robin arbiter that shares one downstream req/ack port between N requesters.
- Once granted, a requester holds the port for a multi-beat burst until it signals its last beat, drops its request, or hits the beat limit.
- Fair replacement for the static-priority arbiter wherever bursts must not be interleaved.
- Sits between the requester array and the shared resource.

Parameters:
- N, 8, number of requesters (2..32).
- MAX_BEATS, 16, maximum beats per grant before forced release (1..2^16-1).
- IDW, $clog2(N), width of the grant index output.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_i  in  N  per-requester request; held high for the whole burst.
- last_i  in  N  per-requester last-beat flag; sampled only on the owner's transfer beat.
- ack_i  out  N  per-requester beat acknowledge.
- req_o  out  1  request to the shared resource.
- ack_o  in  1  acknowledge from the shared resource.
- gnt_o  out  N  registered one-hot owner; all zero when idle.
- gnt_id_o  out  IDW  registered index of the owner; holds its last value when idle.
- busy_o  out  1  registered; high while a grant is locked.

Behaviour:
- Reset (async, rstn=0) sets: state=IDLE, gnt_o=0, gnt_id_o=0, busy_o=0, ptr=0, beat_cnt=0. Consequently req_o=0 and ack_i=0.
- Release takes effect immediately on reset assertion, including mid-burst; any beat in that cycle is lost.
- States are IDLE and LOCK.
- IDLE:
  - req_o=0 and ack_i=0.
  - If req_i!=0, the winner is the first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Next edge: gnt_o=onehot(winner), gnt_id_o=winner, busy_o=1, beat_cnt=0, state=LOCK.
  - If req_i==0, the block stays in IDLE.
  - Arbitration latency: grant is visible 1 cycle after the request is seen.
- LOCK (owner k=gnt_id_o):
  - Combinational: req_o=req_i[k]; ack_i[k]=req_i[k]&ack_o; ack_i[j≠k]=0.
  - A beat occurs when req_i[k]&ack_o; it increments beat_cnt (16-bit, saturating is not needed because of the limit).
  - Release occurs at the edge when any of these holds:
    - (a) beat && last_i[k]
    - (b) req_i[k]==0 (abort; no beat this cycle)
    - (c) beat && beat_cnt==MAX_BEATS-1 (forced)
  - On release: state=IDLE, gnt_o=0, busy_o=0, ptr=(k+1) mod N (wrap N-1 → 0). gnt_id_o keeps k.
  - Simultaneous conditions count as a single release with the same ptr update.
- Re-arbitration always passes through one IDLE cycle. A burst therefore costs 1 bubble cycle, so the maximum port utilisation is MAX_BEATS/(MAX_BEATS+1).
- Fairness:
  - A continuously requesting requester is granted within N-1 other grants.
  - A requester that is forced off by the beat limit goes behind all others.
- Requests from non-owners during LOCK are ignored and have no effect on ptr.
- ack_o with req_o=0 is ignored.
- last_i is ignored outside the owner's beat.

Test Plan (N=4, MAX_BEATS=4):
- Reset then req_i=4'b1010 held, 1-beat bursts (last_i=req_i, ack_o=1) → grant order 1,3,1,3…; gnt_o=0010 the cycle after the request; one IDLE cycle between grants.
- req_i=4'b1111, last_i=4'b1111, ack_o=1 → gnt_id_o sequence 0,1,2,3,0 (wrap-around); each ack_i asserted for exactly one cycle per grant.
- Owner 2, ack_o toggling 1,0,1,0,1, last_i[2] on 3rd beat → exactly 3 ack_i[2] pulses, no acks in ack_o=0 cycles, release after 3rd beat, ptr=3.
- Owner 0, last_i=0, ack_o=1 continuously, req_i=4'b0011 → forced release after 4 beats; requester 1 granted next; requester 0 regranted only after 1.
- Owner 1 drops req_i[1] mid-burst after 2 beats → busy_o falls next edge, req_o=0 that cycle, next arbitration starts from 2.
- Assert rstn=0 asynchronously (between clock edges) mid-burst → gnt_o=0, busy_o=0, ack_i=0, req_o=0 immediately; after release, req_i=4'b1000 → grant goes to 3 (ptr back to 0, first set bit from 0).
